bet_entry_ctrl: RTL and testbench
=================================

Name: bet_entry_ctrl

Overview:
Bet-entry controller sitting between the PS/2 keyboard receiver and the bet opcode decoder on one side, and the regfile bet inputs on the other. It replaces the ad-hoc bet latch and counter. It filters PS/2 break and extended codes and validates each key against the Arduino colour input. Accepted bets go into a 12-slot buffer with undo support, and the buffer is locked while a spin is in progress.

Parameters:
MAX_BETS, 12, number of bet slots (1..15)
OPC_SPIN, 6'b111110, decoded opcode that requests a spin
OPC_NONE, 6'b111111, decoded opcode for an unmapped key
OPC_UNDO, 6'b111101, decoded opcode that removes the most recent bet

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle strobe: rx_byte holds a newly received scan byte
rx_byte  in  8  raw PS/2 scan byte
bet_opcode  in  6  combinational decode of rx_byte (from keyboardToBet)
color  in  3  Arduino chip colour; 3'b000 means no chip present
spin_done  in  1  one-cycle pulse from the processor side: spin finished, payout latched
bets  out  8*MAX_BETS  slot i at bits [8i+7:8i], format {color[1:0], opcode}
bet_count  out  4  number of valid slots
full  out  1  bet_count == MAX_BETS
spin_req  out  1  level; high from spin accept until spin_done
locked  out  1  high in SPIN state
reject  out  1  one-cycle pulse: the key byte was evaluated and refused

Behaviour:
- Reset (synchronous, active-high): takes effect at the rising clock edge. It applies in every state, including mid-spin. Results after reset:
  - state = ACCEPT, all slots = 0, bet_count = 0.
  - spin_req = 0, locked = 0, reject = 0, full = 0.
- Only rx_valid cycles are evaluated. All register updates occur at the same edge that samples rx_valid. There is one cycle of latency from rx_valid to outputs.
- ACCEPT state, evaluated in this priority order:
  1. rx_byte == 8'hF0: go to SKIP, no reject.
  2. rx_byte == 8'hE0: ignore, stay in ACCEPT, no reject.
  3. bet_opcode == OPC_NONE: reject.
  4. bet_opcode == OPC_SPIN:
     - if bet_count > 0: go to SPIN and set spin_req = 1.
     - else: reject.
  5. bet_opcode == OPC_UNDO:
     - if bet_count > 0: clear slot[bet_count-1] to 0 and decrement bet_count.
     - else: reject.
  6. Otherwise (regular bet):
     - if color == 3'b000 or full: reject.
     - else: write slot[bet_count] = {color[1:0], bet_opcode} and increment bet_count.
- SKIP state: the next rx_valid byte (the released key) is discarded without evaluation. Return to ACCEPT. No reject.
- SPIN state:
  - All rx_valid bytes are ignored; no reject is issued.
  - Break-code tracking is not maintained in SPIN. After the spin the FSM always restarts in ACCEPT.
  - On spin_done: clear all slots, bet_count = 0, spin_req = 0, go to ACCEPT.
- spin_done outside SPIN has no effect.
- spin_done together with rx_valid in the same cycle in SPIN: spin_done wins and the byte is dropped.
- Slots never shift: undo removes only the top entry. Contents above bet_count are always 0.
- bet_count saturates at MAX_BETS. Undo at 0 never wraps.
- Combinational outputs: full, locked and bets are decoded from registers. reject is a registered pulse.

Decomposition:
- Shared package roulette_pkg holds:
  - opcode constants OPC_SPIN, OPC_NONE, OPC_UNDO;
  - PS/2 constants PS2_BREAK = 8'hF0 and PS2_EXT = 8'hE0;
  - state encoding ACCEPT, SKIP, SPIN;
  - BET_W = 8.
- One sub-module, bet_slot_stack: the MAX_BETS x 8 register stack with push, pop, clear and a count output. The FSM stays in bet_entry_ctrl.

Test Plan:
- Reset, then key 0x16 with opcode 6'd5 and colour 3'b010 -> slot0 = 8'h85, bet_count = 1, reject = 0.
- Byte 0xF0 then 0x16 (opcode 5, colour 010) -> second byte ignored, bet_count unchanged, no reject.
- Bet with colour 3'b000, and a 13th valid bet when full -> reject pulses for one cycle each, slots unchanged, bet_count = 12.
- Three bets, then OPC_UNDO -> bet_count = 2, slot2 = 0; four further UNDOs -> bet_count = 0 after two of them, then two reject pulses.
- OPC_SPIN at bet_count = 0 -> reject. Then one bet plus OPC_SPIN -> spin_req = 1 and locked = 1; further keys are ignored. spin_done together with rx_valid -> all slots 0, bet_count = 0, state ACCEPT.
- Reset asserted in SPIN with 5 bets -> next edge: all outputs 0 and state ACCEPT.

Source files
------------

// File: rtl/roulette_pkg.sv
// roulette_pkg: shared opcodes, PS/2 codes and bet-entry state encoding
package roulette_pkg;
  localparam int BET_W = 8;
  localparam logic [5:0] OPC_SPIN = 6'b111110;
  localparam logic [5:0] OPC_NONE = 6'b111111;
  localparam logic [5:0] OPC_UNDO = 6'b111101;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  typedef enum logic [1:0] {ACCEPT, SKIP, SPIN} state_e;
endpackage

// File: rtl/bet_slot_stack.sv
// bet_slot_stack: fixed-position bet slots with push, pop-top and clear
module bet_slot_stack
  import roulette_pkg::*;
#(
  parameter int MAX_BETS = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      clr,
  input  logic [BET_W-1:0]          din,
  output logic [BET_W*MAX_BETS-1:0] slots,
  output logic [3:0]                count
);
  logic [BET_W-1:0] slot_q [MAX_BETS];
  logic [BET_W-1:0] slot_d [MAX_BETS];
  logic [3:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = !clr && push && count_q < 4'(MAX_BETS);
    do_pop = !clr && !push && pop && count_q != 4'd0;
    count_d = clr ? 4'd0 : do_push ? count_q + 4'd1 : do_pop ? count_q - 4'd1 : count_q;
    for (int i = 0; i < MAX_BETS; i++) begin
      slot_d[i] = clr ? '0 : slot_q[i];
      if (do_push && 4'(i) == count_q) slot_d[i] = din;
      if (do_pop && 4'(i) == count_q - 4'd1) slot_d[i] = '0;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= 4'd0;
      for (int i = 0; i < MAX_BETS; i++) slot_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < MAX_BETS; i++) slot_q[i] <= slot_d[i];
    end
  end
  for (genvar g = 0; g < MAX_BETS; g++) begin : g_out
    assign slots[g*BET_W +: BET_W] = slot_q[g];
  end
  assign count = count_q;
endmodule

// File: rtl/bet_entry_ctrl.sv
// bet_entry_ctrl: filters PS/2 keys, validates bets and manages the spin lock
module bet_entry_ctrl
  import roulette_pkg::*;
#(
  parameter int MAX_BETS = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rx_valid,
  input  logic [7:0]                rx_byte,
  input  logic [5:0]                bet_opcode,
  input  logic [2:0]                color,
  input  logic                      spin_done,
  output logic [BET_W*MAX_BETS-1:0] bets,
  output logic [3:0]                bet_count,
  output logic                      full,
  output logic                      spin_req,
  output logic                      locked,
  output logic                      reject
);
  state_e state_q, state_d;
  logic reject_q, reject_d;
  logic push, pop, clr;
  bet_slot_stack #(.MAX_BETS(MAX_BETS)) u_stack (
    .clock(clock),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .clr  (clr),
    .din  ({color[1:0], bet_opcode}),
    .slots(bets),
    .count(bet_count)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ACCEPT;
      reject_q <= 1'b0;
    end else begin
      state_q <= state_d;
      reject_q <= reject_d;
    end
  end
  // spin_done outranks a same-cycle byte; in SPIN every byte is dropped
  always_comb begin
    state_d = state_q;
    reject_d = 1'b0;
    push = 1'b0;
    pop = 1'b0;
    clr = 1'b0;
    if (state_q == SPIN) begin
      if (spin_done) begin
        clr = 1'b1;
        state_d = ACCEPT;
      end
    end else if (rx_valid) begin
      if (state_q == SKIP) state_d = ACCEPT;
      else if (rx_byte == PS2_BREAK) state_d = SKIP;
      else if (rx_byte == PS2_EXT) state_d = ACCEPT;
      else if (bet_opcode == OPC_NONE) reject_d = 1'b1;
      else if (bet_opcode == OPC_SPIN) begin
        state_d = bet_count != 4'd0 ? SPIN : ACCEPT;
        reject_d = bet_count == 4'd0;
      end else if (bet_opcode == OPC_UNDO) begin
        pop = bet_count != 4'd0;
        reject_d = bet_count == 4'd0;
      end else begin
        push = color != 3'b000 && !full;
        reject_d = color == 3'b000 || full;
      end
    end
  end
  always_comb begin
    full = bet_count == 4'(MAX_BETS);
    locked = state_q == SPIN;
    spin_req = state_q == SPIN;
    reject = reject_q;
  end
endmodule

// File: tb/tb_bet_entry_ctrl.sv
// tb_bet_entry_ctrl: directed plan plus random keys against a queue-based bet model
module tb_bet_entry_ctrl;
  localparam int MAX = 12;
  localparam logic [5:0] SPN = 6'b111110, NON = 6'b111111, UND = 6'b111101;
  logic clock = 0, reset = 0, rx_valid = 0, spin_done = 0;
  logic [7:0] rx_byte = 0;
  logic [5:0] bet_opcode = 0;
  logic [2:0] color = 0;
  logic [8*MAX-1:0] bets;
  logic [3:0] bet_count;
  logic full, spin_req, locked, reject;
  int tests = 0, fails = 0;
  logic [7:0] q[$];
  int mode = 0;
  bit exp_rej = 0;
  bet_entry_ctrl #(.MAX_BETS(MAX)) dut (
    .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .bet_opcode(bet_opcode), .color(color), .spin_done(spin_done), .bets(bets),
    .bet_count(bet_count), .full(full), .spin_req(spin_req), .locked(locked), .reject(reject)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model(input bit rs, input bit rv, input logic [7:0] b, input logic [5:0] op, input logic [2:0] c, input bit sd);
    exp_rej = 0;
    if (rs) begin q.delete(); mode = 0; end
    else if (mode == 2) begin if (sd) begin q.delete(); mode = 0; end end
    else if (rv) begin
      if (mode == 1) mode = 0;
      else if (b == 8'hF0) mode = 1;
      else if (b == 8'hE0) mode = 0;
      else if (op == NON) exp_rej = 1;
      else if (op == SPN) begin if (q.size() > 0) mode = 2; else exp_rej = 1; end
      else if (op == UND) begin if (q.size() > 0) void'(q.pop_back()); else exp_rej = 1; end
      else if (c == 0 || q.size() == MAX) exp_rej = 1;
      else q.push_back({c[1:0], op});
    end
  endtask
  task automatic check_all(input string tag);
    logic [8*MAX-1:0] eb = '0;
    foreach (q[i]) eb[8*i +: 8] = q[i];
    chk({tag, ".bets"}, 128'(bets), 128'(eb));
    chk({tag, ".count"}, 128'(bet_count), 128'(q.size()));
    chk({tag, ".full"}, 128'(full), 128'(q.size() == MAX));
    chk({tag, ".spin_req"}, 128'(spin_req), 128'(mode == 2));
    chk({tag, ".locked"}, 128'(locked), 128'(mode == 2));
    chk({tag, ".reject"}, 128'(reject), 128'(exp_rej));
  endtask
  task automatic step(input string tag, input bit rs, input bit rv, input logic [7:0] b,
                      input logic [5:0] op, input logic [2:0] c, input bit sd);
    @(negedge clock);
    reset = rs; rx_valid = rv; rx_byte = b; bet_opcode = op; color = c; spin_done = sd;
    model(rs, rv, b, op, c, sd);
    @(posedge clock);
    #1;
    reset = 0; rx_valid = 0; spin_done = 0;
    check_all(tag);
  endtask
  task automatic key(input string tag, input logic [5:0] op, input logic [2:0] c);
    step(tag, 0, 1, 8'h16, op, c, 0);
  endtask
  task automatic idle(input string tag);
    step(tag, 0, 0, 8'h00, 6'd0, 3'd0, 0);
  endtask
  initial begin
    step("reset", 1, 0, 0, 0, 0, 0);
    key("bet1", 6'd5, 3'b010);
    chk("slot0_85", 128'(bets[7:0]), 128'(8'h85));
    step("break", 0, 1, 8'hF0, 6'd5, 3'b010, 0);
    key("released", 6'd5, 3'b010);
    step("ext", 0, 1, 8'hE0, 6'd5, 3'b010, 0);
    key("nocolor", 6'd7, 3'b000);
    idle("nocolor_pulse_end");
    key("unmapped", NON, 3'b001);
    for (int i = 0; i < 11; i++) key("fill", 6'(i + 1), 3'b011);
    chk("full12", 128'(bet_count), 128'(12));
    key("over", 6'd9, 3'b001);
    idle("over_pulse_end");
    step("reset2", 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) key("three", 6'(i + 2), 3'b101);
    key("undo1", UND, 3'b000);
    chk("undo_slot2", 128'(bets[23:16]), 128'(0));
    for (int i = 0; i < 4; i++) key("undoN", UND, 3'b000);
    key("spin_empty", SPN, 3'b000);
    key("bet_for_spin", 6'd12, 3'b001);
    key("spin", SPN, 3'b000);
    key("ignored_in_spin", 6'd3, 3'b010);
    step("ignored_break", 0, 1, 8'hF0, 6'd0, 3'd0, 0);
    step("done_with_rx", 0, 1, 8'h16, 6'd4, 3'b010, 1);
    key("after_spin", 6'd4, 3'b010);
    for (int i = 0; i < 4; i++) key("pre5", 6'(i + 20), 3'b110);
    key("spin5", SPN, 3'b000);
    step("reset_in_spin", 1, 0, 0, 0, 0, 0);
    key("post_reset", 6'd8, 3'b001);
    for (int n = 0; n < 600; n++) begin
      int r = $urandom_range(0, 99);
      logic [7:0] b = (r < 8) ? 8'hF0 : (r < 11) ? 8'hE0 : 8'($urandom_range(0, 255));
      logic [5:0] op = (r < 20) ? UND : (r < 26) ? SPN : (r < 30) ? NON : 6'($urandom_range(0, 60));
      step("rand", $urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, b, op,
           3'($urandom_range(0, 7)), $urandom_range(0, 5) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
